// File: rtl/vinst_issue.sv
// Instruction issue queue: host pushes sa_inst_t words, the vector controller
// sees the oldest word show-ahead and retires it with a one-cycle ird pulse.
package vinst_pkg;
  typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [8:0] imm;
  } sa_inst_t;
endpackage

module vinst_issue
  import vinst_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hwr,
  input  sa_inst_t      hinst,
  output logic          hfull,
  input  logic          flush,
  output sa_inst_t      inst,
  output logic          iavail,
  input  logic          ird,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf,
  input  logic          clr_err
);

  sa_inst_t       mem [DEPTH];
  logic [AW-1:0]  wp;
  logic [AW-1:0]  rp;
  logic [AW:0]    cnt;
  logic           push;
  logic           pop;
  logic           drop_evt;
  logic           udf_evt;

  // Valid/ready: a word transfers in on hwr while !hfull, and out on ird while
  // iavail; every output is derived from registered state only.
  assign hfull  = (cnt == (AW+1)'(DEPTH));
  assign iavail = (cnt != '0);
  assign level  = cnt;
  assign inst   = iavail ? mem[rp] : '0;

  assign push     = hwr & ~hfull;
  assign pop      = ird & iavail;
  assign drop_evt = hwr & hfull;
  assign udf_evt  = ird & ~iavail;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      cnt <= cnt + (AW+1)'(1);
      else if (pop && !push) cnt <= cnt - (AW+1)'(1);
    end
  end

  // Error flags: a same-cycle event beats clr_err; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (drop_evt)     ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (udf_evt)      udf <= 1'b1;
      else if (clr_err) udf <= 1'b0;
    end
  end

  // Storage has no reset; stale words are never visible because cnt gates inst.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[wp] <= hinst;
  end

endmodule

// File: tb/tb_vinst_issue.sv
// Randomized scoreboard bench for vinst_issue against a queue-based model.
module tb_vinst_issue;
  import vinst_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int W     = $bits(sa_inst_t);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          hwr = 1'b0;
  sa_inst_t      hinst = '0;
  logic          hfull;
  logic          flush = 1'b0;
  sa_inst_t      inst;
  logic          iavail;
  logic          ird = 1'b0;
  logic [AW:0]   level;
  logic          ovf;
  logic          udf;
  logic          clr_err = 1'b0;

  vinst_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .hwr(hwr), .hinst(hinst), .hfull(hfull),
    .flush(flush), .inst(inst), .iavail(iavail), .ird(ird), .level(level),
    .ovf(ovf), .udf(udf), .clr_err(clr_err)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // reference model: contents as a plain queue, flags as bits
  logic [W-1:0] model_q[$];
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: every accepted pop must show the oldest outstanding word
  always @(negedge clk) begin
    if (reset && !flush && ird && iavail) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_data: got %h with no word expected at %0t", inst, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (inst !== e) begin
          n_err++;
          $display("FAIL pop_data: got %h expected %h at %0t", inst, e, $time);
        end
      end
    end
  end

  task automatic check_state();
    check("level",  W'(level),  W'(model_q.size()));
    check("iavail", W'(iavail), W'(model_q.size() != 0));
    check("hfull",  W'(hfull),  W'(model_q.size() == DEPTH));
    check("ovf",    W'(ovf),    W'(m_ovf));
    check("udf",    W'(udf),    W'(m_udf));
    check("inst",   W'(inst),   (model_q.size() != 0) ? model_q[0] : '0);
  endtask

  function automatic sa_inst_t mk(input int op);
    sa_inst_t w;
    w = sa_inst_t'($urandom());
    w.opcode = 8'(op);
    return w;
  endfunction

  // driver: called #1 after a rising edge; applies one cycle and updates model
  task automatic cycle(input logic w, input logic r, input logic f, input logic c,
                       input sa_inst_t d);
    logic full, empty;
    hwr = w; ird = r; flush = f; clr_err = c; hinst = d;
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    if (w && full)       m_ovf = 1'b1;
    else if (c)          m_ovf = 1'b0;
    if (r && empty)      m_udf = 1'b1;
    else if (c)          m_udf = 1'b0;
    if (f) begin
      model_q.delete();
    end else begin
      if (r && !empty) exp_q.push_back(model_q.pop_front());
      if (w && !full)  model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    hwr = 1'b0; ird = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_state();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
    check_state();
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(2);

    // fill and drain with overflow
    for (int i = 1; i <= 8; i++) cycle(1, 0, 0, 0, mk(i));
    cycle(1, 0, 0, 0, mk(9));
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 0, 1, '0);

    // steady push+pop at level 3 across the pointer wrap
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, mk(16 + i));
    for (int i = 0; i < 20; i++) cycle(1, 1, 0, 0, mk(32 + i));

    // push+pop at full: push dropped, level drops to 7
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, mk(64 + i));
    cycle(1, 1, 0, 0, mk(99));

    // drain, then underflow with a same-cycle push
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0, '0);
    cycle(0, 0, 0, 1, '0);
    cycle(1, 1, 0, 0, mk(5));
    cycle(0, 0, 0, 1, '0);

    // flush at level 5 with a push, then refill and reset mid-traffic
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, mk(80 + i));
    cycle(1, 0, 1, 0, mk(90));
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, mk(100 + i));
    do_reset(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 199);
      if (sel == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
              1'(sel < 3), 1'($urandom_range(0, 99) < 4), mk($urandom_range(0, 255)));
      end
    end

    @(negedge clk);
    check("scoreboard_empty", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
